branch_resolve_unit: RTL and testbench

- Parametrised successor to the execute-stage branch comparator.
- Resolves RV32/RV64 conditional branches; unsigned mode is taken from funct3[1], not a separate input.
- Computes branch target and fall-through, registers the result one cycle, and flags mispredicts against the fetch-stage prediction.
- Owns a 2-bit-counter branch history table (BHT) read by fetch and trained at resolve; keeps saturating branch/mispredict statistics for the perf CSRs.

---
 rtl/branch_resolve_unit.sv | 120 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: compares operands, computes the redirect PC,
// registers the outcome one cycle later, trains a 2-bit BHT and keeps stats.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  input  logic             e_valid,
  input  logic [6:0]       e_opcode,
  input  logic [2:0]       e_funct3,
  input  logic [XLEN-1:0]  e_pc,
  input  logic [XLEN-1:0]  e_imm,
  input  logic [XLEN-1:0]  e_rs1,
  input  logic [XLEN-1:0]  e_rs2,
  input  logic             e_pred_taken,
  input  logic             flush,
  output logic             r_valid,
  output logic             r_taken,
  output logic             r_mispredict,
  output logic [XLEN-1:0]  r_redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int         BHT_N      = 1 << BHT_IDX_W;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [BHT_N-1:0][1:0] bht_q, bht_d;
  logic                  r_valid_q, r_valid_d;
  logic                  r_taken_q, r_taken_d;
  logic                  r_mispredict_q, r_mispredict_d;
  logic [XLEN-1:0]       r_redirect_pc_q, r_redirect_pc_d;
  logic [CNT_W-1:0]      br_count_q, br_count_d;
  logic [CNT_W-1:0]      mispred_count_q, mispred_count_d;

  logic [BHT_IDX_W-1:0]  f_idx, e_idx;
  logic                  funct3_legal, br, eq, lt, outcome;
  logic [XLEN-1:0]       target, fall_through;
  logic [1:0]            cnt_cur;
  logic                  unused_pc_bits;

  assign f_idx          = f_pc[BHT_IDX_W+1:2];
  assign e_idx          = e_pc[BHT_IDX_W+1:2];
  assign unused_pc_bits = ^{f_pc[XLEN-1:BHT_IDX_W+2], f_pc[1:0]};

  // Combinational read of the registered array: a same-cycle update is not seen.
  assign f_pred_taken = bht_q[f_idx][1];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    funct3_legal = 1'b0;
    case (e_funct3)
      3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111: funct3_legal = 1'b1;
      default:                                        funct3_legal = 1'b0;
    endcase
  end

  // funct3[2] picks lt vs eq, funct3[0] inverts, funct3[1] selects unsigned compare.
  always_comb begin
    br           = e_valid & ~flush & (e_opcode == OPC_BRANCH) & funct3_legal;
    eq           = (e_rs1 == e_rs2);
    lt           = e_funct3[1] ? (e_rs1 < e_rs2) : ($signed(e_rs1) < $signed(e_rs2));
    outcome      = (e_funct3[2] ? lt : eq) ^ e_funct3[0];
    target       = e_pc + e_imm;
    fall_through = e_pc + XLEN'(4);
  end

  always_comb begin
    r_valid_d       = br;
    r_taken_d       = br & outcome;
    r_mispredict_d  = br & (outcome ^ e_pred_taken);
    r_redirect_pc_d = r_redirect_pc_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    bht_d           = bht_q;
    cnt_cur         = bht_q[e_idx];
    if (br) begin
      r_redirect_pc_d = outcome ? target : fall_through;
      if (!(&br_count_q)) br_count_d = br_count_q + CNT_W'(1);
      if ((outcome ^ e_pred_taken) && !(&mispred_count_q))
        mispred_count_d = mispred_count_q + CNT_W'(1);
      if (outcome && cnt_cur != 2'b11)       bht_d[e_idx] = cnt_cur + 2'b01;
      else if (!outcome && cnt_cur != 2'b00) bht_d[e_idx] = cnt_cur - 2'b01;
    end
  end

  // NOTE: the BHT is a flop array, so it can and must be reset to weakly not-taken.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!reset) begin
      bht_q           <= {BHT_N{2'b01}};
      r_valid_q       <= 1'b0;
      r_taken_q       <= 1'b0;
      r_mispredict_q  <= 1'b0;
      r_redirect_pc_q <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      bht_q           <= bht_d;
      r_valid_q       <= r_valid_d;
      r_taken_q       <= r_taken_d;
      r_mispredict_q  <= r_mispredict_d;
      r_redirect_pc_q <= r_redirect_pc_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign r_valid       = r_valid_q;
  assign r_taken       = r_taken_q;
  assign r_mispredict  = r_mispredict_q;
  assign r_redirect_pc = r_redirect_pc_q;
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: default instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter saturation.
module tb_branch_resolve_unit;

  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_ALU = 7'b0110011;

  logic        clock, reset;
  logic [31:0] f_pc, e_pc, e_imm, e_rs1, e_rs2;
  logic        e_valid, e_pred_taken, flush;
  logic [6:0]  e_opcode;
  logic [2:0]  e_funct3;

  logic        f_pred_taken, r_valid, r_taken, r_mispredict;
  logic [31:0] r_redirect_pc, br_count, mispred_count;

  logic        c4_f_pred_taken, c4_r_valid, c4_r_taken, c4_r_mispredict;
  logic [31:0] c4_r_redirect_pc;
  logic [3:0]  c4_br_count, c4_mispred_count;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit dut (
    .clock(clock), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .e_valid(e_valid), .e_opcode(e_opcode), .e_funct3(e_funct3), .e_pc(e_pc),
    .e_imm(e_imm), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_pred_taken(e_pred_taken),
    .flush(flush), .r_valid(r_valid), .r_taken(r_taken), .r_mispredict(r_mispredict),
    .r_redirect_pc(r_redirect_pc), .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_resolve_unit #(.CNT_W(4)) dut_c4 (
    .clock(clock), .reset(reset), .f_pc(f_pc), .f_pred_taken(c4_f_pred_taken),
    .e_valid(e_valid), .e_opcode(e_opcode), .e_funct3(e_funct3), .e_pc(e_pc),
    .e_imm(e_imm), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_pred_taken(e_pred_taken),
    .flush(flush), .r_valid(c4_r_valid), .r_taken(c4_r_taken),
    .r_mispredict(c4_r_mispredict), .r_redirect_pc(c4_r_redirect_pc),
    .br_count(c4_br_count), .mispred_count(c4_mispred_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic pred, input logic fl);
    e_valid = v; e_opcode = opc; e_funct3 = f3; e_pc = pc; e_imm = imm;
    e_rs1 = rs1; e_rs2 = rs2; e_pred_taken = pred; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_r(input string tag, input logic v, input logic t,
                          input logic m, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(r_valid), 64'(v));
    check({tag, ".taken"}, 64'(r_taken), 64'(t));
    check({tag, ".mispredict"}, 64'(r_mispredict), 64'(m));
    check({tag, ".redirect"}, 64'(r_redirect_pc), 64'(pc));
  endtask

  task automatic expect_pred(input string tag, input logic [31:0] pc, input logic exp);
    f_pc = pc;
    #1;
    check(tag, 64'(f_pred_taken), 64'(exp));
  endtask

  initial begin
    reset = 1'b0;
    f_pc  = 32'd0;
    idle();
    tick();
    tick();

    // Reset state
    expect_pred("rst_pred_0", 32'h0, 1'b0);
    expect_pred("rst_pred_40", 32'h40, 1'b0);
    expect_pred("rst_pred_100", 32'h100, 1'b0);
    expect_r("rst", 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_br_count", 64'(br_count), 64'd0);
    check("rst_mispred_count", 64'(mispred_count), 64'd0);

    reset = 1'b1;
    // BEQ 5==5 at 0x100, imm 0x20, predicted not-taken
    drive(1'b1, OPC_BR, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 1'b0);
    tick();
    expect_r("beq", 1'b1, 1'b1, 1'b1, 32'h120);
    check("beq_mispred_count", 64'(mispred_count), 64'd1);
    check("beq_br_count", 64'(br_count), 64'd1);

    // Signed vs unsigned compare, back to back: -1 vs 1
    drive(1'b1, OPC_BR, 3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    tick();
    expect_r("blt", 1'b1, 1'b1, 1'b0, 32'h210);
    drive(1'b1, OPC_BR, 3'b110, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    tick();
    expect_r("bltu", 1'b1, 1'b0, 1'b1, 32'h204);
    drive(1'b1, OPC_BR, 3'b101, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    tick();
    expect_r("bge", 1'b1, 1'b0, 1'b0, 32'h204);
    drive(1'b1, OPC_BR, 3'b111, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    tick();
    expect_r("bgeu", 1'b1, 1'b1, 1'b1, 32'h210);
    check("cmp_br_count", 64'(br_count), 64'd5);
    check("cmp_mispred_count", 64'(mispred_count), 64'd3);

    // BHT training at 0x40: 01 -> 10 -> 11 -> 11, then 11 -> 10 -> 01
    drive(1'b1, OPC_BR, 3'b001, 32'h40, 32'h8, 32'd1, 32'd2, 1'b0, 1'b0);
    expect_pred("bht_rbw_before", 32'h40, 1'b0);
    tick();
    expect_pred("bht_t1", 32'h40, 1'b1);
    expect_pred("bht_alias_t1", 32'h140, 1'b1);
    expect_r("bne_t1", 1'b1, 1'b1, 1'b1, 32'h48);
    tick();
    expect_pred("bht_t2", 32'h40, 1'b1);
    tick();
    expect_pred("bht_t3", 32'h40, 1'b1);
    tick();
    expect_pred("bht_t4", 32'h40, 1'b1);
    drive(1'b1, OPC_BR, 3'b001, 32'h40, 32'h8, 32'd3, 32'd3, 1'b1, 1'b0);
    tick();
    expect_pred("bht_n1", 32'h40, 1'b1);
    expect_r("bne_n1", 1'b1, 1'b0, 1'b1, 32'h44);
    tick();
    expect_pred("bht_n2", 32'h40, 1'b0);
    expect_pred("bht_alias_n2", 32'h140, 1'b0);
    check("bht_br_count", 64'(br_count), 64'd11);
    check("bht_mispred_count", 64'(mispred_count), 64'd9);

    // Flushed taken BNE at 0x80: nothing recorded
    drive(1'b1, OPC_BR, 3'b001, 32'h80, 32'h8, 32'd1, 32'd2, 1'b0, 1'b1);
    tick();
    check("flush_valid", 64'(r_valid), 64'd0);
    check("flush_taken", 64'(r_taken), 64'd0);
    check("flush_mispredict", 64'(r_mispredict), 64'd0);
    check("flush_br_count", 64'(br_count), 64'd11);
    check("flush_mispred_count", 64'(mispred_count), 64'd9);
    expect_pred("flush_bht", 32'h80, 1'b0);

    // Non-branch opcode, then illegal funct3 010 with equal operands
    drive(1'b1, OPC_ALU, 3'b000, 32'h80, 32'h8, 32'd4, 32'd4, 1'b0, 1'b0);
    tick();
    check("alu_valid", 64'(r_valid), 64'd0);
    drive(1'b1, OPC_BR, 3'b010, 32'h80, 32'h8, 32'd4, 32'd4, 1'b0, 1'b0);
    tick();
    check("f3_010_valid", 64'(r_valid), 64'd0);
    check("f3_010_br_count", 64'(br_count), 64'd11);
    expect_pred("f3_010_bht", 32'h80, 1'b0);

    // PC wrap on target and on fall-through
    drive(1'b1, OPC_BR, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'd7, 32'd7, 1'b1, 1'b0);
    tick();
    expect_r("wrap_target", 1'b1, 1'b1, 1'b0, 32'h4);
    drive(1'b1, OPC_BR, 3'b001, 32'hFFFF_FFFC, 32'h8, 32'd7, 32'd7, 1'b0, 1'b0);
    tick();
    expect_r("wrap_fall", 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    tick();
    check("idle_valid", 64'(r_valid), 64'd0);
    check("idle_redirect_hold", 64'(r_redirect_pc), 64'h0);
    check("pre_rst_br_count", 64'(br_count), 64'd13);
    check("pre_rst_mispred_count", 64'(mispred_count), 64'd9);
    check("pre_rst_c4_br_count", 64'(c4_br_count), 64'd13);
    expect_pred("pre_rst_bht_idx0", 32'h100, 1'b1);

    // Reset mid-stream with a branch in flight
    reset = 1'b0;
    drive(1'b1, OPC_BR, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 1'b0);
    tick();
    expect_r("mid_rst", 1'b0, 1'b0, 1'b0, 32'h0);
    check("mid_rst_br_count", 64'(br_count), 64'd0);
    check("mid_rst_mispred_count", 64'(mispred_count), 64'd0);
    expect_pred("mid_rst_bht_idx0", 32'h100, 1'b0);

    // 17 back-to-back taken branches: CNT_W=4 instance saturates at 15
    reset = 1'b1;
    drive(1'b1, OPC_BR, 3'b000, 32'h300, 32'h40, 32'd9, 32'd9, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) tick();
    expect_r("b2b_last", 1'b1, 1'b1, 1'b0, 32'h340);
    check("b2b_br_count", 64'(br_count), 64'd17);
    check("b2b_c4_br_count", 64'(c4_br_count), 64'd15);
    check("b2b_c4_mispred_count", 64'(c4_mispred_count), 64'd0);
    idle();
    tick();
    check("b2b_c4_hold", 64'(c4_br_count), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
